// File: rtl/aes_axil_block_stager.sv
// AXI4-Lite register front end that stages one 128-bit block into the AES round core
// and captures its result. Optional irq output is enabled by defining AES_STAGER_IRQ_EN.
module aes_axil_block_stager #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter bit WORD_SWAP          = 1'b0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            blk_valid,
  input  logic                            blk_ready,
  output logic [127:0]                    blk_data,
  output logic                            blk_mode,
`ifdef AES_STAGER_IRQ_EN
  output logic                            irq,
`endif
  input  logic                            res_valid,
  input  logic [127:0]                    res_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_next;

  logic         r_mode;
  logic         r_done;
  logic         r_bvalid;
  logic [1:0]   r_bresp;
  logic         r_rvalid;
  logic [31:0]  r_rdata;
  logic [127:0] r_blk_data;
  logic         r_blk_mode;

  logic [31:0]  w_din [4];
  logic [31:0]  w_dout [4];
  logic [127:0] w_din_packed;
  logic [31:0]  w_rmux;
  logic [3:0]   w_wsel;
  logic [3:0]   w_rsel;
  logic         w_ie;
  logic         w_busy;
  logic         w_wr_fire;
  logic         w_wr_reject;
  logic         w_wr_apply;
  logic         w_ctrl_wr;
  logic         w_start;
  logic         w_done_clr;
  logic         w_res_take;
  logic         w_rd_fire;
  logic         w_unused;

  assign w_wsel      = S_AXI_AWADDR[5:2];
  assign w_rsel      = S_AXI_ARADDR[5:2];
  assign w_busy      = (r_state != S_IDLE);
  assign w_wr_fire   = S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~S_AXI_ARESET;
  // DIN0-3 and CTRL are frozen while a block is in flight
  assign w_wr_reject = w_wr_fire & w_busy & (w_wsel <= 4'd4);
  assign w_wr_apply  = w_wr_fire & ~w_wr_reject;
  assign w_ctrl_wr   = w_wr_apply & (w_wsel == 4'd4) & S_AXI_WSTRB[0];
  assign w_start     = w_ctrl_wr & S_AXI_WDATA[0];
  assign w_done_clr  = w_wr_apply & (w_wsel == 4'd5) & S_AXI_WSTRB[0] & S_AXI_WDATA[1];
  assign w_res_take  = (r_state == S_WAIT) & res_valid;
  assign w_rd_fire   = S_AXI_ARVALID & ~r_rvalid & ~S_AXI_ARESET;
  assign w_unused    = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = w_wr_fire;
  assign S_AXI_WREADY  = w_wr_fire;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = w_rd_fire;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign blk_valid     = (r_state == S_SEND);
  assign blk_data      = r_blk_data;
  assign blk_mode      = r_blk_mode;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      localparam int SLOT = WORD_SWAP ? (3 - gi) : gi;
      logic [31:0] r_din_word;
      logic [31:0] r_dout_word;

      always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
          r_din_word <= '0;
        end else if (w_wr_apply && (w_wsel == 4'(gi))) begin
          for (int b = 0; b < 4; b++) begin
            if (S_AXI_WSTRB[b]) r_din_word[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
          end
        end
      end

      always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) r_dout_word <= '0;
        else if (w_res_take) r_dout_word <= res_data[32*SLOT +: 32];
      end

      assign w_din[gi]                    = r_din_word;
      assign w_dout[gi]                   = r_dout_word;
      assign w_din_packed[32*SLOT +: 32]  = r_din_word;
    end
  endgenerate

`ifdef AES_STAGER_IRQ_EN
  logic r_ie;
  logic r_irq;
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ie <= S_AXI_WDATA[2];
      r_irq <= r_done & r_ie;
    end
  end
  assign w_ie = r_ie;
  assign irq  = r_irq;
`else
  assign w_ie = 1'b0;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_mode <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_mode <= S_AXI_WDATA[1];
      // a completing block outranks a simultaneous clear
      if (w_res_take) r_done <= 1'b1;
      else if (w_done_clr) r_done <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) r_state <= S_IDLE;
    else r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_SEND;
      S_SEND:  if (blk_ready) w_state_next = S_WAIT;
      S_WAIT:  if (res_valid) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_blk_data <= '0;
      r_blk_mode <= 1'b0;
    end else if (w_start) begin
      r_blk_data <= w_din_packed;
      r_blk_mode <= S_AXI_WDATA[1];
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end else if (w_wr_fire) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_reject ? 2'b10 : 2'b00;
    end else if (S_AXI_BREADY) begin
      r_bvalid <= 1'b0;
    end
  end

  always_comb begin
    w_rmux = '0;
    case (w_rsel)
      4'd0:    w_rmux = w_din[0];
      4'd1:    w_rmux = w_din[1];
      4'd2:    w_rmux = w_din[2];
      4'd3:    w_rmux = w_din[3];
      4'd4:    w_rmux = {29'd0, w_ie, r_mode, 1'b0};
      4'd5:    w_rmux = {30'd0, r_done, w_busy};
      4'd6:    w_rmux = w_dout[0];
      4'd7:    w_rmux = w_dout[1];
      4'd8:    w_rmux = w_dout[2];
      4'd9:    w_rmux = w_dout[3];
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_rd_fire) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rmux;
    end else if (S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_axil_block_stager.sv
// Randomised self-checking bench for aes_axil_block_stager against a transaction-level model.
module tb_aes_axil_block_stager;
  localparam bit WS = 1'b0;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         blk_valid, blk_ready, blk_mode, res_valid;
  logic [127:0] blk_data, res_data;
`ifdef AES_STAGER_IRQ_EN
  logic         irq;
`endif

  always #5 clk = ~clk;

  aes_axil_block_stager #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .WORD_SWAP(WS)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_mode(blk_mode),
`ifdef AES_STAGER_IRQ_EN
    .irq(irq),
`endif
    .res_valid(res_valid), .res_data(res_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;

  always @(posedge clk) if (blk_valid && blk_ready) hs_cnt <= hs_cnt + 1;

  // Reference model: register contents and the phase of the block in flight
  logic [31:0]  m_din [4];
  logic [31:0]  m_dout [4];
  logic [127:0] m_blk;
  logic         m_mode, m_blk_mode, m_ie, m_done;
  int           m_phase;  // 0 idle, 1 offered to core, 2 awaiting result

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] w0, w1, w2, w3);
    return WS ? {w0, w1, w2, w3} : {w3, w2, w1, w0};
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] v, input int i);
    return WS ? v[32*(3-i) +: 32] : v[32*i +: 32];
  endfunction

  function automatic logic [31:0] mdl_read(input logic [5:0] a);
    int w;
    w = int'(a[5:2]);
    if (w < 4) return m_din[w];
    if (w == 4) return {29'd0, m_ie, m_mode, 1'b0};
    if (w == 5) return {30'd0, m_done, (m_phase != 0)};
    if (w >= 6 && w <= 9) return m_dout[w-6];
    return 32'd0;
  endfunction

  task automatic mdl_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int w;
    w = int'(a[5:2]);
    resp = 2'b00;
    if (w <= 4 && m_phase != 0) begin
      resp = 2'b10;
    end else if (w < 4) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_din[w][8*b +: 8] = d[8*b +: 8];
    end else if (w == 4 && s[0]) begin
      m_mode = d[1];
`ifdef AES_STAGER_IRQ_EN
      m_ie = d[2];
`endif
      if (d[0]) begin
        m_blk      = pack4(m_din[0], m_din[1], m_din[2], m_din[3]);
        m_blk_mode = m_mode;
        m_phase    = 1;
      end
    end else if (w == 5 && s[0] && d[1]) begin
      m_done = 1'b0;
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 4; i++) begin m_din[i] = '0; m_dout[i] = '0; end
    m_blk = '0; m_mode = 0; m_blk_mode = 0; m_ie = 0; m_done = 0; m_phase = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    blk_ready = 0; res_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_reset();
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int k;
    k = 0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; #1;
    while (!(awready && wready) && k < 50) begin @(negedge clk); #1; k++; end
    if (k >= 50) check_eq("aw_ready", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    k = 0;
    while (!bvalid && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) check_eq("b_valid", bvalid, 1'b1);
    resp = bresp;
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int k;
    k = 0;
    @(negedge clk);
    araddr = a; arvalid = 1; #1;
    while (!arready && k < 50) begin @(negedge clk); #1; k++; end
    if (k >= 50) check_eq("ar_ready", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 0;
    k = 0;
    while (!rvalid && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) check_eq("r_valid", rvalid, 1'b1);
    d = rdata; resp = rresp;
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] got, exp;
    mdl_write(a, d, s, exp);
    axi_write(a, d, s, got);
    $display("[TB] WR a=%h d=%h s=%h bresp=%0d", a, d, s, got);
    check_eq($sformatf("bresp@%h", a), got, exp);
  endtask

  task automatic do_read(input logic [5:0] a);
    logic [31:0] got;
    logic [1:0]  r;
    axi_read(a, got, r);
    $display("[TB] RD a=%h d=%h rresp=%0d", a, got, r);
    check_eq($sformatf("rdata@%h", a), got, mdl_read(a));
    check_eq($sformatf("rresp@%h", a), r, 2'b00);
  endtask

  task automatic core_accept(input int hold);
    check_eq("blk_valid_on", blk_valid, 1'b1);
    check_eq("blk_data", blk_data, m_blk);
    check_eq("blk_mode", blk_mode, m_blk_mode);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("blk_hold_valid", blk_valid, 1'b1);
      check_eq("blk_hold_data", blk_data, m_blk);
    end
    @(negedge clk);
    blk_ready = 1;
    @(posedge clk); #1;
    blk_ready = 0;
    m_phase = 2;
    $display("[TB] CORE accept data=%h mode=%0d", blk_data, blk_mode);
    check_eq("blk_valid_off", blk_valid, 1'b0);
  endtask

  task automatic core_result(input logic [127:0] d);
    @(negedge clk);
    res_valid = 1; res_data = d;
    @(posedge clk); #1;
    res_valid = 0;
    $display("[TB] CORE result %h phase=%0d", d, m_phase);
    if (m_phase == 2) begin
      for (int i = 0; i < 4; i++) m_dout[i] = word_of(d, i);
      m_done  = 1'b1;
      m_phase = 0;
    end
  endtask

  task automatic read_all_dout();
    for (int i = 0; i < 4; i++) do_read(6'(8'h18 + 4*i));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs0;
    logic [127:0] r;
    logic [1:0] junk;
    rst = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0; blk_ready = 0; res_valid = 0; res_data = 0;
    mdl_reset();
    apply_reset();
    @(negedge clk);
    check_eq("rst_bvalid", bvalid, 1'b0);
    check_eq("rst_rvalid", rvalid, 1'b0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_blk", {blk_valid, blk_mode, blk_data}, 130'd0);
    do_read(6'h00);
    do_read(6'h14);

    // directed: DIN write/readback and partial strobes
    for (int i = 0; i < 4; i++) do_write(6'(4*i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) do_read(6'(4*i));
    do_write(6'h00, 32'hFFFF_FFFF, 4'h5);
    do_read(6'h00);
    check_eq("strb_literal", mdl_read(6'h00), 32'h00FF_00FF);
    do_write(6'h00, 32'h1, 4'hF);

    // directed: start, stalled core, busy protection
    hs0 = hs_cnt;
    do_write(6'h10, 32'h1, 4'hF);
    check_eq("blk_literal", blk_data, WS ? 128'h1_00000002_00000003_00000004
                                          : 128'h4_00000003_00000002_00000001);
    do_read(6'h14);
    do_write(6'h04, 32'hDEAD, 4'hF);
    do_write(6'h10, 32'h3, 4'hF);
    do_read(6'h04);
    do_read(6'h10);
    core_accept(3);
    core_result(128'hA5A5A5A5_11223344_55667788_99AA5A5A);
    repeat (3) @(negedge clk);
    check_eq("one_handshake", hs_cnt - hs0, 1);
    check_eq("no_reoffer", blk_valid, 1'b0);
    do_read(6'h14);
    read_all_dout();
    do_write(6'h14, 32'h2, 4'hF);
    do_read(6'h14);

    // res_valid while idle must not disturb DOUT or DONE
    core_result(128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    do_read(6'h14);
    do_read(6'h18);

    // DONE set and clear in the same cycle: set wins
    do_write(6'h10, 32'h3, 4'hF);
    core_accept(0);
    r = {$urandom, $urandom, $urandom, $urandom};
    mdl_write(6'h14, 32'h2, 4'hF, junk);
    fork
      axi_write(6'h14, 32'h2, 4'hF, junk);
      core_result(r);
    join
    check_eq("clr_bresp", junk, 2'b00);
    do_read(6'h14);
    read_all_dout();
    do_write(6'h14, 32'h2, 4'hF);

    // randomised blocks
    for (int it = 0; it < 20; it++) begin
      for (int w = 0; w < 4; w++) do_write(6'(4*w), $urandom, 4'($urandom_range(0, 15)));
      do_read(6'(4*$urandom_range(0, 3)));
      do_read(6'(4*$urandom_range(10, 15)));
      do_write(6'(4*$urandom_range(10, 15)), $urandom, 4'hF);
      do_write(6'h10, {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1}, 4'hF);
      do_read(6'h10);
      if ($urandom_range(0, 1) == 1) do_write(6'(4*$urandom_range(0, 3)), $urandom, 4'hF);
      core_accept($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) core_result({$urandom, $urandom, $urandom, $urandom});
      core_result({$urandom, $urandom, $urandom, $urandom});
      do_read(6'h14);
      read_all_dout();
      if ($urandom_range(0, 2) != 0) do_write(6'h14, 32'h2, 4'hF);
      do_read(6'h14);
    end

`ifdef AES_STAGER_IRQ_EN
    do_write(6'h14, 32'h2, 4'hF);
    do_write(6'h10, 32'h5, 4'hF);
    core_accept(1);
    core_result({$urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    check_eq("irq_set", irq, 1'b1);
    do_write(6'h14, 32'h2, 4'hF);
    check_eq("irq_clr", irq, 1'b0);
`endif

    // reset while waiting on the core drops the block; a late result is ignored
    do_write(6'h10, 32'h1, 4'hF);
    core_accept(0);
    apply_reset();
    core_result({$urandom, $urandom, $urandom, $urandom});
    do_read(6'h14);
    do_read(6'h18);
    do_read(6'h04);
    check_eq("rst_wait_blk_valid", blk_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
